// File: rtl/approx_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// The approximate cell is selected by defining APPROX_SUB_CELL_EN.
package approx_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_t;

   // The carry starts at 1 so that a + ~b + 1 gives a - b in two's complement.
   localparam logic CARRY_INIT = 1'b1;
   localparam logic FLAG_INIT  = 1'b0;

endpackage : approx_sub_pkg

// File: rtl/serial_sub_cell.sv
// One bit step of the serial subtractor: (x, y, c, f) -> (s, co, fo).
// The exact full-adder body is the default; APPROX_SUB_CELL_EN selects the propagate-flag approximation.
module serial_sub_cell (
   input  logic x,
   input  logic y,
   input  logic c,
   input  logic f,
   output logic s,
   output logic co,
   output logic fo
);

`ifdef APPROX_SUB_CELL_EN
   logic p;

   // The flag generated by this bit steers the sum and carry of the next bit.
   assign fo = x & y;
   assign p  = (x | y) & ~c;
   assign s  = ~(~f & p);
   assign co = f & p;
`else
   logic unused_f;

   // The exact cell has no use for the flag input.
   assign unused_f = f;
   assign s        = x ^ y ^ c;
   assign co       = (x & y) | (x & c) | (y & c);
   assign fo       = 1'b0;
`endif

endmodule : serial_sub_cell

// File: rtl/approx_serial_subtractor.sv
// Bit-serial two's-complement subtractor, diff = a - b, LSB first, one bit per clock.
// Cell body is exact by default; define APPROX_SUB_CELL_EN for the approximate cell.
module approx_serial_subtractor
   import approx_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   sub_state_t       state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             c_q, c_d;
   logic             f_q, f_d;

   logic cell_s;
   logic cell_co;
   logic cell_fo;

   serial_sub_cell u_cell (
      .x  (a_sh_q[0]),
      .y  (~b_sh_q[0]),
      .c  (c_q),
      .f  (f_q),
      .s  (cell_s),
      .co (cell_co),
      .fo (cell_fo)
   );

   always_comb begin
      // NOTE: every signal driven here gets a default first so no path can leave it unassigned and infer a latch.
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      f_d     = f_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sh_d  = a;
               b_sh_d  = b;
               c_d     = CARRY_INIT;
               f_d     = FLAG_INIT;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            diff_d = {cell_s, diff_q[WIDTH-1:1]};
            c_d    = cell_co;
            f_d    = cell_fo;
            // The counter holds at its last value rather than wrapping.
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         f_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         f_q     <= f_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign diff       = diff_q;
   // Borrow is only meaningful once the last bit is in; elsewhere it reads 0.
   assign borrow_out = out_valid & ~c_q;

endmodule : approx_serial_subtractor

// File: tb/tb_approx_serial_subtractor.sv
// Self-checking bench for approx_serial_subtractor: directed steps, scoreboard of expected results.
module tb_approx_serial_subtractor;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         borrow_out;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int acc_cyc  = 0;
   bit ov_prev  = 1'b0;
   bit b2b      = 1'b0;
   bit b2b_have = 1'b0;

   logic [W:0] sb[$];

   approx_serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .diff       (diff),
      .borrow_out (borrow_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Expected {borrow, diff} for one operand pair.
   function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
`ifdef APPROX_SUB_CELL_EN
      logic         c, f, x, y, p, s, co, fo;
      logic [W-1:0] d;
      c = 1'b1;
      f = 1'b0;
      d = '0;
      for (int i = 0; i < W; i++) begin
         x    = av[i];
         y    = ~bv[i];
         fo   = x & y;
         p    = (x | y) & ~c;
         s    = ~(~f & p);
         co   = f & p;
         d[i] = s;
         c    = co;
         f    = fo;
      end
      return {~c, d};
`else
      logic [W-1:0] d;
      d = av - bv;
      return {(av < bv), d};
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Scoreboard and handshake monitor, sampled mid-cycle.
   always @(negedge clk) begin
      logic [W:0] e;
      if (!rst_n) begin
         sb.delete();
         ov_prev  = 1'b0;
         b2b_have = 1'b0;
      end else begin
         if (out_valid && !ov_prev) check("latency", cyc - acc_cyc, W + 1);
         ov_prev = out_valid;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               e = sb.pop_front();
               check("diff", diff, e[W-1:0]);
               check("borrow_out", borrow_out, e[W]);
            end
         end
         if (in_valid && in_ready) begin
            if (b2b && b2b_have) check("accept_gap", cyc - acc_cyc, W + 2);
            sb.push_back(model(a, b));
            acc_cyc  = cyc;
            b2b_have = b2b;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
   task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("drain_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [W:0] hold_exp;
      bit         ok;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      #3;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_diff", diff, 0);
      check("rst_borrow", borrow_out, 0);
      #9 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic operand patterns, including equal operands and a borrow.
      send(8'h05, 8'h03);
      wait_drain();
      send(8'h03, 8'h05);
      wait_drain();
      send(8'hFF, 8'hFF);
      wait_drain();
      send(8'h00, 8'h00);
      wait_drain();
      send(8'h80, 8'h7F);
      wait_drain();

      // Backpressure, with operand noise while running.
      out_ready = 1'b0;
      hold_exp  = model(8'hA5, 8'h3C);
      send(8'hA5, 8'h3C);
      for (int i = 0; i < 4; i++) begin
         in_valid = i[0];
         a        = 8'h11 + 8'(i);
         b        = 8'h77 - 8'(i);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("done_timeout", 0, 1);
      for (int i = 0; i < 5; i++) begin
         check("hold_out_valid", out_valid, 1);
         check("hold_diff", diff, hold_exp[W-1:0]);
         check("hold_in_ready", in_ready, 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_drain();

      // Asynchronous reset three bits into an operation.
      send(8'hFF, 8'h00);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_diff", diff, 0);
      check("mid_rst_borrow", borrow_out, 0);
      sb.delete();
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(8'h10, 8'h01);
      wait_drain();

      // Back-to-back with in_valid held high.
      b2b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         a        = 8'h30 + 8'(i * 37);
         b        = 8'h55 - 8'(i * 19);
         ok       = 1'b0;
         for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (in_ready) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) check("b2b_timeout", 0, 1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      wait_drain();
      b2b = 1'b0;

      check("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_approx_serial_subtractor
